// File: rtl/ex_if.sv
// ex_if: ID/EX operands and controls in, EX/MEM boundary and flags out; FORWARDING_EN adds bypass inputs
interface ex_if #(
    parameter int WIDTH = 8,
    parameter int RADDR = 3
);
    logic             stall;
    logic             flush;
    logic [WIDTH-1:0] r1;
    logic [WIDTH-1:0] r2;
    logic [WIDTH-1:0] const_disp;
    logic [2:0]       sc;
    logic [RADDR-1:0] dest;
    logic [3:0]       alu_function;
    logic             alu_input_b_sel;
    logic             dm_mem_write;
    logic             reg_write;
    logic             reg_write_data_sel;
    logic             z_enb;
    logic             c_enb;
`ifdef FORWARDING_EN
    logic [RADDR-1:0] src1;
    logic [RADDR-1:0] src2;
    logic             mem_fwd_we;
    logic [RADDR-1:0] mem_fwd_dest;
    logic [WIDTH-1:0] mem_fwd_data;
    logic             wb_fwd_we;
    logic [RADDR-1:0] wb_fwd_dest;
    logic [WIDTH-1:0] wb_fwd_data;
`endif
    logic [WIDTH-1:0] alu_result_q;
    logic [WIDTH-1:0] store_data_q;
    logic [RADDR-1:0] dest_q;
    logic             dm_mem_write_q;
    logic             reg_write_q;
    logic             reg_write_data_sel_q;
    logic             z_flag;
    logic             c_flag;

    modport master (
        output stall, flush, r1, r2, const_disp, sc, dest, alu_function, alu_input_b_sel,
               dm_mem_write, reg_write, reg_write_data_sel, z_enb, c_enb,
`ifdef FORWARDING_EN
        output src1, src2, mem_fwd_we, mem_fwd_dest, mem_fwd_data,
               wb_fwd_we, wb_fwd_dest, wb_fwd_data,
`endif
        input  alu_result_q, store_data_q, dest_q, dm_mem_write_q, reg_write_q,
               reg_write_data_sel_q, z_flag, c_flag
    );

    modport slave (
        input  stall, flush, r1, r2, const_disp, sc, dest, alu_function, alu_input_b_sel,
               dm_mem_write, reg_write, reg_write_data_sel, z_enb, c_enb,
`ifdef FORWARDING_EN
        input  src1, src2, mem_fwd_we, mem_fwd_dest, mem_fwd_data,
               wb_fwd_we, wb_fwd_dest, wb_fwd_data,
`endif
        output alu_result_q, store_data_q, dest_q, dm_mem_write_q, reg_write_q,
               reg_write_data_sel_q, z_flag, c_flag
    );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: execute stage (operand select, ALU/shifter, Z/C flags, EX/MEM register); FORWARDING_EN enables MEM/WB bypass
module ex_stage #(
    parameter int WIDTH = 8,
    parameter int RADDR = 3
) (
    input logic clk,
    input logic rst,
    ex_if.slave ex
);
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_r2;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH:0]     arith;
    logic [2*WIDTH-1:0] wide;
    logic [WIDTH-1:0]   alu_result_d;
    logic               c_d;
    logic               c_aff;
    logic               z_d;
    logic               cin;

`ifdef FORWARDING_EN
    assign op_a  = (ex.src1 != '0 && ex.mem_fwd_we && ex.mem_fwd_dest == ex.src1) ? ex.mem_fwd_data :
                   (ex.src1 != '0 && ex.wb_fwd_we  && ex.wb_fwd_dest  == ex.src1) ? ex.wb_fwd_data  : ex.r1;
    assign op_r2 = (ex.src2 != '0 && ex.mem_fwd_we && ex.mem_fwd_dest == ex.src2) ? ex.mem_fwd_data :
                   (ex.src2 != '0 && ex.wb_fwd_we  && ex.wb_fwd_dest  == ex.src2) ? ex.wb_fwd_data  : ex.r2;
`else
    assign op_a  = ex.r1;
    assign op_r2 = ex.r2;
`endif
    assign op_b = ex.alu_input_b_sel ? ex.const_disp : op_r2;
    assign cin  = ex.alu_function[0] & ex.c_flag;
    assign z_d  = (alu_result_d == '0);

    // ALU and shifter; shifts use a double-width vector so the last bit out lands at a fixed position
    always_comb begin
        arith        = '0;
        wide         = '0;
        alu_result_d = op_a;
        c_d          = 1'b0;
        c_aff        = 1'b1;
        case (ex.alu_function)
            4'd0, 4'd1: begin
                arith        = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};
                alu_result_d = arith[WIDTH-1:0];
                c_d          = arith[WIDTH];
            end
            4'd2, 4'd3: begin
                arith        = {1'b0, op_a} - {1'b0, op_b} - {{WIDTH{1'b0}}, cin};
                alu_result_d = arith[WIDTH-1:0];
                c_d          = arith[WIDTH];
            end
            4'd4: alu_result_d = op_a & op_b;
            4'd5: alu_result_d = op_a | op_b;
            4'd6: alu_result_d = op_a ^ op_b;
            4'd7: alu_result_d = op_b;
            4'd8: begin
                wide         = {{WIDTH{1'b0}}, op_a} << ex.sc;
                alu_result_d = wide[WIDTH-1:0];
                c_d          = wide[WIDTH];
            end
            4'd9: begin
                wide         = {op_a, {WIDTH{1'b0}}} >> ex.sc;
                alu_result_d = wide[2*WIDTH-1:WIDTH];
                c_d          = wide[WIDTH-1];
            end
            4'd10: begin
                wide         = {op_a, op_a} << ex.sc;
                alu_result_d = wide[2*WIDTH-1:WIDTH];
                c_d          = (ex.sc != 3'd0) & wide[WIDTH];
            end
            4'd11: begin
                wide         = {op_a, op_a} >> ex.sc;
                alu_result_d = wide[WIDTH-1:0];
                c_d          = (ex.sc != 3'd0) & wide[WIDTH-1];
            end
            default: c_aff = 1'b0;
        endcase
    end

    // EX/MEM boundary and flags: reset clears, flush bubbles with flags held, stall freezes everything
    always_ff @(posedge clk) begin
        if (rst) begin
            ex.alu_result_q         <= '0;
            ex.store_data_q         <= '0;
            ex.dest_q               <= '0;
            ex.dm_mem_write_q       <= 1'b0;
            ex.reg_write_q          <= 1'b0;
            ex.reg_write_data_sel_q <= 1'b0;
            ex.z_flag               <= 1'b0;
            ex.c_flag               <= 1'b0;
        end else if (ex.flush) begin
            ex.alu_result_q         <= '0;
            ex.store_data_q         <= '0;
            ex.dest_q               <= '0;
            ex.dm_mem_write_q       <= 1'b0;
            ex.reg_write_q          <= 1'b0;
            ex.reg_write_data_sel_q <= 1'b0;
        end else if (!ex.stall) begin
            ex.alu_result_q         <= alu_result_d;
            ex.store_data_q         <= op_r2;
            ex.dest_q               <= ex.dest;
            ex.dm_mem_write_q       <= ex.dm_mem_write;
            ex.reg_write_q          <= ex.reg_write;
            ex.reg_write_data_sel_q <= ex.reg_write_data_sel;
            if (ex.z_enb) ex.z_flag <= z_d;
            if (ex.c_enb && c_aff) ex.c_flag <= c_d;
        end
    end
endmodule
